seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Mealy sequence detector: successor to the fixed consecutive-ones detectors.
- Detects a run-time-loadable PATTERN_W-bit serial pattern on a 1-bit input stream.
- Selectable overlapping or non-overlapping detection, plus a saturating match counter.
- Sits on serial input paths (framing/sync-word search), one bit per enabled clock.

Parameters:
PATTERN_W, 4, pattern length in bits (2..16)
PATTERN_INIT, 4'b1011, pattern loaded at reset (PATTERN_W bits)
CNT_W, 8, match counter width

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
en  input  1  x is valid this cycle; when low, state and counter hold
x  input  1  serial data bit
load  input  1  latch pattern_in into pattern register and restart search
pattern_in  input  PATTERN_W  new pattern; bit PATTERN_W-1 is the first bit expected
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle
clr  input  1  synchronous clear of match_cnt
detect  output  1  Mealy match: combinational, same cycle as the final pattern bit
detect_q  output  1  detect registered (1-cycle latency)
match_cnt  output  CNT_W  number of matches, saturating
state_o  output  clog2(PATTERN_W)  current matched-prefix length k (0..PATTERN_W-1)

Behaviour:
- Reset (rstn low, async): k=0, pattern_reg=PATTERN_INIT, match_cnt=0, detect_q=0; detect=0 while rstn low.
- State k is the number of leading pattern bits currently matched by the most recent inputs.
- Cycle with en=1, load=0:
  - Expected bit e = pattern_reg[PATTERN_W-1-k].
  - If x==e and k<PATTERN_W-1: k <= k+1.
  - If x==e and k==PATTERN_W-1: detect=1 (combinational). Next k = overlap ? B : 0, where B is the longest proper border of pattern_reg (longest j<PATTERN_W with the pattern's j-bit suffix equal to its j-bit prefix).
  - If x!=e: k <= largest j<=k such that the last j received bits (matched k-prefix followed by x) equal the pattern's j-bit prefix; 0 if none.
- en=0: k, match_cnt hold; detect=0; detect_q <= 0.
- load=1 (any en): pattern_reg <= pattern_in, k <= 0, detect=0; the x of that cycle is discarded. load has priority over en.
- detect is a function of k, x, en, load and pattern_reg only; no glitch filtering required. detect_q <= detect every cycle.
- match_cnt:
  - clr=1: match_cnt <= 0; clr wins over a simultaneous detect.
  - Else if detect: match_cnt <= match_cnt+1, holding at 2^CNT_W-1 (no wrap).
- Reset asserted mid-sequence: all state lost immediately; the search restarts from k=0 with PATTERN_INIT.
- Mode change (overlap toggled) affects only the next match's restart value; k is never reset by a mode change.
- All-same patterns (e.g. 1111): B=PATTERN_W-1; in overlap mode, every further matching bit detects.

Decomposition:
- Package seq_det_pkg: constant for the state width (clog2 PATTERN_W), and a function that computes the failure/next-state value from (pattern, k, x).
- Sub-module seq_det_next: purely combinational next-k and border computation (loop over j, generate-friendly). The top holds the registers, counter and outputs.

Test Plan:
- PATTERN_W=4, pattern 1011, overlap=1, stream 1,0,1,1,0,1,1 -> detect high on bits 4 and 7; detect_q one cycle later each; match_cnt=2.
- Same stream, overlap=0 -> detect only on bit 4; k=1 after bit 7; match_cnt=1.
- load pattern 1111, overlap=1, eight 1s -> detect on bits 4..8 (5 pulses). With overlap=0 -> detect on bits 4 and 8 only.
- en toggled low between every bit of 1,0,1,1 -> k holds during en=0; single detect on the 4th enabled bit; detect=0 in every en=0 cycle.
- CNT_W=2, six matches of 1011 (overlap=0), then clr asserted together with a 7th match -> match_cnt reads 1,2,3,3,3,3 after each match, then 0.
- Apply 1,0,1, then rstn low for 1 cycle, then 1 -> k=1 and no detect. Separately, apply 1,0,1, then load=1 with x=1 -> k=0, no detect, new pattern active on the next bit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector: state width and the
// mismatch fallback (longest pattern prefix ending at the newest bit).
package seq_det_pkg;

  localparam int MAX_W = 16;

  function automatic int state_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Bit i of the pattern in arrival order (i=0 is the first bit expected).
  function automatic logic pbit(input logic [MAX_W-1:0] pat, input int w, input int i);
    return |((pat >> (w - 1 - i)) & MAX_W'(1));
  endfunction

  // After a mismatch at prefix length k: the received tail is prefix(k) then x.
  // Return the longest j<=k whose last-j tail bits equal prefix(j).
  function automatic int fail_next(input logic [MAX_W-1:0] pat, input int w,
                                   input int k, input logic x);
    int   best;
    int   pos;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j < MAX_W; j++) begin
      if (j <= k) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_W; t++) begin
          if (t < j) begin
            pos = k + 1 - j + t;
            sb  = (pos == k) ? x : pbit(pat, w, pos);
            if (sb != pbit(pat, w, t)) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-prefix logic: expected-bit compare, full-match flag,
// pattern border for overlapping restarts and mismatch fallback.
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = 4,
  parameter int SW        = 2
) (
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic [SW-1:0]        k_i,
  input  logic                 x_i,
  input  logic                 overlap_i,
  output logic                 match_o,
  output logic [SW-1:0]        k_next_o
);

  logic [SW-1:0] border;
  logic          ok;
  logic          hit;

  always_comb begin
    border = '0;
    ok     = 1'b0;
    for (int j = 1; j < PATTERN_W; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) begin
        if (pbit(MAX_W'(pattern_i), PATTERN_W, PATTERN_W - j + t) !=
            pbit(MAX_W'(pattern_i), PATTERN_W, t)) ok = 1'b0;
      end
      if (ok) border = SW'(j);
    end
  end

  always_comb begin
    hit      = (x_i == pbit(MAX_W'(pattern_i), PATTERN_W, int'(k_i)));
    match_o  = hit && (k_i == SW'(PATTERN_W - 1));
    k_next_o = '0;
    if (match_o) begin
      k_next_o = overlap_i ? border : '0;
    end else if (hit) begin
      k_next_o = k_i + SW'(1);
    end else begin
      k_next_o = SW'(fail_next(MAX_W'(pattern_i), PATTERN_W, int'(k_i), x_i));
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy detector for a run-time loadable serial pattern with overlap select,
// registered detect and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W    = 4,
  parameter logic [PATTERN_W-1:0] PATTERN_INIT = 4'b1011,
  parameter int                   CNT_W        = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          x,
  input  logic                          load,
  input  logic [PATTERN_W-1:0]          pattern_in,
  input  logic                          overlap,
  input  logic                          clr,
  output logic                          detect,
  output logic                          detect_q,
  output logic [CNT_W-1:0]              match_cnt,
  output logic [state_w(PATTERN_W)-1:0] state_o
);

  localparam int SW = state_w(PATTERN_W);

  logic [SW-1:0]        k_q, k_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 det_q;
  logic                 match;
  logic [SW-1:0]        k_nxt;

  seq_det_next #(
    .PATTERN_W (PATTERN_W),
    .SW        (SW)
  ) u_next (
    .pattern_i (pattern_q),
    .k_i       (k_q),
    .x_i       (x),
    .overlap_i (overlap),
    .match_o   (match),
    .k_next_o  (k_nxt)
  );

  always_comb begin
    detect    = rstn && en && !load && match;
    k_d       = k_q;
    pattern_d = pattern_q;
    if (load) begin
      // A load restarts the search; this cycle's x is discarded.
      pattern_d = pattern_in;
      k_d       = '0;
    end else if (en) begin
      k_d = k_nxt;
    end
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (detect && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q       <= '0;
      pattern_q <= PATTERN_INIT;
      cnt_q     <= '0;
      det_q     <= 1'b0;
    end else begin
      k_q       <= k_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      det_q     <= detect;
    end
  end

  assign detect_q  = det_q;
  assign match_cnt = cnt_q;
  assign state_o   = k_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded bench for seq_detector_param: a history-based reference model
// predicts each cycle, a negedge monitor compares.
module tb_seq_detector_param;

  localparam int             PW   = 4;
  localparam int             CW   = 2;
  localparam int             SW   = 2;
  localparam logic [PW-1:0]  INIT = 4'b1011;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0, x = 1'b0, load = 1'b0, overlap = 1'b0, clr = 1'b0;
  logic [PW-1:0] pattern_in = '0;
  logic          detect, detect_q;
  logic [CW-1:0] match_cnt;
  logic [SW-1:0] state_o;

  seq_detector_param #(
    .PATTERN_W    (PW),
    .PATTERN_INIT (INIT),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .x          (x),
    .load       (load),
    .pattern_in (pattern_in),
    .overlap    (overlap),
    .clr        (clr),
    .detect     (detect),
    .detect_q   (detect_q),
    .match_cnt  (match_cnt),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          det;
    logic [SW-1:0] k;
    logic [CW-1:0] cnt;
    logic          dq;
  } exp_t;

  exp_t          q[$];
  bit            hist[$];
  logic [PW-1:0] pat_m;
  int            cnt_m;
  logic          dq_m;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mbit(input int t);
    logic [PW-1:0] s;
    s = pat_m >> (PW - 1 - t);
    return s[0];
  endfunction

  // Longest proper pattern prefix that the received history ends with.
  function automatic int model_k();
    int n;
    bit ok;
    n = hist.size();
    for (int j = PW - 1; j >= 1; j--) begin
      if (n >= j) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++)
          if (hist[n - j + t] != mbit(t)) ok = 1'b0;
        if (ok) return j;
      end
    end
    return 0;
  endfunction

  // True when the history plus bit xi ends with the full pattern.
  function automatic bit model_hit(input bit xi);
    int n;
    n = hist.size();
    if (n < PW - 1) return 1'b0;
    for (int t = 0; t < PW - 1; t++)
      if (hist[n - (PW - 1) + t] != mbit(t)) return 1'b0;
    return xi == mbit(PW - 1);
  endfunction

  task automatic step(input logic e, input logic xi, input logic ld,
                      input logic [PW-1:0] pin, input logic ov, input logic cl);
    exp_t r;
    logic d;
    en = e; x = xi; load = ld; pattern_in = pin; overlap = ov; clr = cl;
    d     = e && !ld && model_hit(xi);
    r.det = d;
    r.k   = SW'(model_k());
    r.cnt = CW'(cnt_m);
    r.dq  = dq_m;
    q.push_back(r);
    if (ld) begin
      pat_m = pin;
      hist.delete();
    end else if (e) begin
      if (d && !ov) begin
        hist.delete();
      end else begin
        hist.push_back(xi);
        if (hist.size() > PW) void'(hist.pop_front());
      end
    end
    if (cl) cnt_m = 0;
    else if (d && cnt_m < (1 << CW) - 1) cnt_m++;
    dq_m = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    exp_t r;
    rstn = 1'b0; en = 1'b0; load = 1'b0; clr = 1'b0;
    r = '0;
    q.push_back(r);
    pat_m = INIT; hist.delete(); cnt_m = 0; dq_m = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic stream(input logic [15:0] v, input int n, input logic ov);
    logic [15:0] s;
    for (int i = n - 1; i >= 0; i--) begin
      s = v >> i;
      step(1'b1, s[0], 1'b0, 4'h0, ov, 1'b0);
    end
  endtask

  initial begin
    exp_t r;
    logic ov_cur;
    fork
      begin : driver
        @(posedge clk); #1;
        do_reset();
        // overlapping 1011 over 1011011
        stream(16'b1011011, 7, 1'b1);
        chk("ovl_cnt", 16'(match_cnt), 16'd2);
        do_reset();
        stream(16'b1011011, 7, 1'b0);
        chk("novl_cnt", 16'(match_cnt), 16'd1);
        chk("novl_k", 16'(state_o), 16'd1);
        // all-ones pattern
        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        stream(16'hFF, 8, 1'b1);
        chk("ones_ovl_sat", 16'(match_cnt), 16'd3);
        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
        stream(16'hFF, 8, 1'b0);
        chk("ones_novl_cnt", 16'(match_cnt), 16'd2);
        // en gapped between bits
        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
          logic [3:0] b;
          b = 4'b1011 >> i;
          step(1'b1, b[0], 1'b0, 4'h0, 1'b0, 1'b0);
          step(1'b0, 1'($urandom_range(1)), 1'b0, 4'h0, 1'b0, 1'b0);
        end
        chk("gap_cnt", 16'(match_cnt), 16'd1);
        // saturation, then clr colliding with a match
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) stream(16'b1011, 4, 1'b0);
        chk("sat_cnt", 16'(match_cnt), 16'd3);
        stream(16'b101, 3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("clr_wins", 16'(match_cnt), 16'd0);
        // reset mid-sequence
        do_reset();
        stream(16'b101, 3, 1'b1);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("rst_mid_k", 16'(state_o), 16'd1);
        // load mid-sequence
        do_reset();
        stream(16'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
        chk("load_k", 16'(state_o), 16'd0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("load_newpat_k", 16'(state_o), 16'd1);
        // random traffic
        ov_cur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
          if ($urandom_range(199) == 0) begin
            do_reset();
          end else begin
            if ($urandom_range(31) == 0) ov_cur = ~ov_cur;
            step($urandom_range(3) != 0, 1'($urandom_range(1)),
                 $urandom_range(63) == 0, 4'($urandom_range(15)), ov_cur,
                 $urandom_range(15) == 0);
          end
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
          @(negedge clk); #1;
        end
        if (q.size() != 0) chk("drain_timeout", 16'(q.size()), 16'd0);
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (q.size() > 0) begin
            r = q.pop_front();
            chk("detect", 16'(detect), 16'(r.det));
            chk("state_o", 16'(state_o), 16'(r.k));
            chk("match_cnt", 16'(match_cnt), 16'(r.cnt));
            chk("detect_q", 16'(detect_q), 16'(r.dq));
          end
        end
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
